// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin arbiter/sequencer for a shared 8:1 single-bit mux.
// Grants one of eight requesters, drives the 3-bit select and registers the
// selected data bit with a valid flag.
// Optional feature macro: ARB8_QUANTUM_EN (time-sliced tenure, QUANTUM cycles).
module mux8_arbiter #(
    parameter int QUANTUM = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       y,
    output logic       valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Out-of-range quantum leaves this block in the hierarchy as a visible marker.
    if (QUANTUM < 1 || QUANTUM > 15) begin : g_quantum_out_of_range
    end

    logic [0:0] state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] s_q, s_d;
    logic [2:0] ptr_q, ptr_d;
    logic       y_q, y_d;
    logic       valid_q, valid_d;

    logic [7:0] own_oh;
    logic [7:0] elig;
    logic       q_exp;
    logic       rel;
    logic       arb;
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;

    assign own_oh = 8'b1 << s_q;

`ifdef ARB8_QUANTUM_EN
    localparam logic [3:0] QLAST = 4'(QUANTUM - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       others;

    // Quantum expiry only forces a release when someone else is waiting.
    always_comb begin
        others = |(req & ~own_oh);
        q_exp  = (state_q == GRANT) && (cnt_q == QLAST) && others;
    end
`else
    assign q_exp = 1'b0;
`endif

    assign rel  = (state_q == GRANT) && (!req[s_q] || q_exp);
    assign arb  = (state_q == IDLE) || rel;
    // The releasing owner never re-wins the same arbitration round.
    assign elig = req & ~((state_q == GRANT) ? own_oh : 8'h00);

    // Round-robin search starting at ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state: arbitrate on idle/release, otherwise hold the owner.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
`ifdef ARB8_QUANTUM_EN
        cnt_d   = cnt_q;
`endif
        if (arb) begin
            if (found) begin
                state_d = GRANT;
                gnt_d   = 8'b1 << win;
                s_d     = win;
                ptr_d   = win + 3'd1;
`ifdef ARB8_QUANTUM_EN
                cnt_d   = 4'd0;
`endif
            end else begin
                state_d = IDLE;
                gnt_d   = 8'h00;
            end
        end else begin
`ifdef ARB8_QUANTUM_EN
            cnt_d = (cnt_q == QLAST) ? 4'd0 : cnt_q + 4'd1;
`endif
        end
        // Data follows the pre-edge owner so the final cycle's bit is kept.
        y_d     = (state_q == GRANT) ? d[s_q] : 1'b0;
        valid_d = (state_q == GRANT);
    end

    // State registers; reset wins over any same-edge event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            s_q     <= 3'd0;
            ptr_q   <= 3'd0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
`ifdef ARB8_QUANTUM_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef ARB8_QUANTUM_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Self-checking bench for mux8_arbiter: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural owner/pointer model.
module tb_mux8_arbiter;

    localparam int QUANTUM = 4;
`ifdef ARB8_QUANTUM_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] d = 8'h00;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       y;
    logic       valid;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = none), rotating pointer, tenure count.
    int m_own = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_s   = 0;
    bit m_y   = 1'b0;
    bit m_v   = 1'b0;

    mux8_arbiter #(.QUANTUM(QUANTUM)) dut (
        .clk(clk), .reset(reset), .req(req), .d(d),
        .gnt(gnt), .s(s), .y(y), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit rel;
        bit won;
        int others;
        if (reset) begin
            m_own = -1; m_ptr = 0; m_cnt = 0; m_s = 0; m_y = 0; m_v = 0;
            return;
        end
        m_v = (m_own >= 0);
        m_y = (m_own >= 0) ? d[m_own] : 1'b0;
        others = (m_own >= 0) ? (int'(req) & ~(1 << m_own)) : 0;
        rel = (m_own >= 0) &&
              (!req[m_own] || (QEN && m_cnt == QUANTUM - 1 && others != 0));
        if (m_own < 0 || rel) begin
            won = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_ptr + k) % 8;
                if (!won && req[i] && i != m_own) begin
                    won = 1'b1;
                    m_own = i; m_s = i; m_ptr = (i + 1) % 8; m_cnt = 0;
                end
            end
            if (!won) m_own = -1;
        end else begin
            m_cnt = (m_cnt == QUANTUM - 1) ? 0 : m_cnt + 1;
        end
    endtask

    // One clock: update model, let the edge pass, compare away from the edge.
    task automatic step();
        logic [7:0] eg;
        model_edge();
        @(posedge clk);
        #1;
        eg = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
        chk("gnt", gnt, eg);
        chk("s", {5'd0, s}, 8'(m_s));
        chk("y", {7'd0, y}, {7'd0, m_y});
        chk("valid", {7'd0, valid}, {7'd0, m_v});
    endtask

    initial begin
        // Reset state
        reset = 1'b1; req = 8'h00; d = 8'h00;
        step(); step();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_s", {5'd0, s}, 8'h00);
        chk("rst_valid", {7'd0, valid}, 8'h00);
        reset = 1'b0;

        // Single request
        d = 8'h01; req = 8'h01;
        step();
        chk("single_gnt", gnt, 8'h01);
        chk("single_valid0", {7'd0, valid}, 8'h00);
        step();
        chk("single_valid", {7'd0, valid}, 8'h01);
        chk("single_y", {7'd0, y}, 8'h01);
        req = 8'h00;
        step();
        chk("drop_gnt", gnt, 8'h00);
        chk("drop_last_valid", {7'd0, valid}, 8'h01);
        step();
        chk("drop_valid", {7'd0, valid}, 8'h00);

        // Simultaneous requests from reset, then zero-bubble handover and wrap
        reset = 1'b1; step(); reset = 1'b0;
        d = 8'h90; req = 8'h90;
        step();
        chk("simul_gnt", gnt, 8'h10);
        chk("simul_s", {5'd0, s}, 8'h04);
        step(); step();
        chk("simul_hold", gnt, 8'h10);
        req = 8'h80;
        step();
        chk("handover_gnt", gnt, 8'h80);
        chk("handover_s", {5'd0, s}, 8'h07);
        chk("handover_valid", {7'd0, valid}, 8'h01);
        req = 8'h81;
        step();
        chk("wrap_hold", gnt, 8'h80);
        req = 8'h01;
        step();
        chk("wrap_gnt", gnt, 8'h01);
        chk("wrap_valid", {7'd0, valid}, 8'h01);
        req = 8'h00; step(); step();

        // Tenure behaviour
        reset = 1'b1; step(); reset = 1'b0;
        d = 8'h02; req = 8'h03;
`ifdef ARB8_QUANTUM_EN
        for (int k = 0; k < 16; k++) begin
            step();
            chk("quantum_gnt", gnt, ((k / QUANTUM) % 2 == 0) ? 8'h01 : 8'h02);
            if (k > 0) chk("quantum_valid", {7'd0, valid}, 8'h01);
        end
        req = 8'h01;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("quantum_solo", gnt, 8'h01);
        end
`else
        for (int k = 0; k < 20; k++) begin
            step();
            chk("noquantum_gnt", gnt, 8'h01);
        end
        req = 8'h02;
        step();
        chk("noquantum_next", gnt, 8'h02);
`endif
        req = 8'h00; step(); step();

        // Reset mid-grant
        reset = 1'b1; step(); reset = 1'b0;
        d = 8'h20; req = 8'h20;
        step();
        chk("mid_gnt", gnt, 8'h20);
        step();
        chk("mid_valid", {7'd0, valid}, 8'h01);
        reset = 1'b1;
        step();
        chk("midrst_gnt", gnt, 8'h00);
        chk("midrst_s", {5'd0, s}, 8'h00);
        chk("midrst_y", {7'd0, y}, 8'h00);
        chk("midrst_valid", {7'd0, valid}, 8'h00);
        reset = 1'b0;
        step();
        chk("regrant_gnt", gnt, 8'h20);
        chk("regrant_s", {5'd0, s}, 8'h05);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
